// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage controller: FSM states,
// condition codes, CPSR flag positions and op-class encodings.
package ex_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] OC_B     = 3'b000;
  localparam logic [2:0] OC_BCOND = 3'b001;
  localparam logic [2:0] OC_SYS   = 3'b111;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_ctrl_cond.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from the 4-bit condition field and the current {N,C,Z,V} flags.
module cond_eval
  import ex_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  logic n, c, z, v;
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_EQ: take = z;
      CC_NE: take = !z;
      CC_CS: take = c;
      CC_CC: take = !c;
      CC_MI: take = n;
      CC_PL: take = !n;
      CC_VS: take = v;
      CC_VC: take = !v;
      CC_HI: take = c && !z;
      CC_LS: take = !(c && !z);
      CC_GE: take = (n == v);
      CC_LT: take = (n != v);
      CC_GT: take = !z && (n == v);
      CC_LE: take = !(!z && (n == v));
      CC_AL: take = 1'b1;
      CC_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller: owns the PC, the
// latched instruction and the CPSR, and sequences one instruction at a time.
module ex_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        fetch_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  output logic [31:0] pc,
  input  logic        dec_special,
  input  logic [1:0]  dec_first_ld,
  input  logic [2:0]  dec_alu_oc,
  input  logic [3:0]  dec_b_cond,
  input  logic        dec_set_flags,
  input  logic [15:0] dec_offset,
  input  logic [3:0]  ex_flags,
  output logic        w_enable,
  output logic [3:0]  cpsr,
  output logic        branch_taken,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_reg_q, instr_d;
  logic [3:0]  cpsr_q, cpsr_d;
  logic        wb_we_q, wb_we_d;
  logic        take_q, take_d;
  logic [15:0] offset_q, offset_d;

  logic is_sys, is_br, cond_take, br_take, wb_we;

  // Decode classification is only meaningful while in EXECUTE.
  assign is_sys = !dec_special && (dec_first_ld != 2'b00) && (dec_alu_oc == OC_SYS);
  assign is_br  = !dec_special && (dec_first_ld != 2'b00) &&
                  ((dec_alu_oc == OC_B) || (dec_alu_oc == OC_BCOND));
  assign wb_we  = dec_special || (dec_first_ld == 2'b00);

  cond_eval u_cond (
    .cond  (dec_b_cond),
    .flags (cpsr_q),
    .take  (cond_take)
  );

  assign br_take = is_br && ((dec_alu_oc == OC_B) || cond_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     if (imem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = is_sys ? S_HALT : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req    = (state_q == S_FETCH);
    w_enable     = (state_q == S_WRITEBACK) && wb_we_q;
    branch_taken = (state_q == S_WRITEBACK) && take_q;
    halted       = (state_q == S_HALT);
  end

  // Branch decision and write strobe are captured at the end of EXECUTE so
  // WRITEBACK does not depend on the decoder holding its outputs.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_reg_q;
    cpsr_d   = cpsr_q;
    wb_we_d  = wb_we_q;
    take_d   = take_q;
    offset_d = offset_q;
    case (state_q)
      S_FETCH: if (imem_ready) instr_d = imem_rdata;
      S_EXECUTE: begin
        wb_we_d  = wb_we;
        take_d   = br_take;
        offset_d = dec_offset;
        if (dec_special && dec_set_flags) cpsr_d = ex_flags;
      end
      S_WRITEBACK: pc_d = take_q ? (pc_q + sext16(offset_q)) : (pc_q + PC_STEP);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      instr_reg_q <= 32'h0;
      cpsr_q      <= 4'b0000;
      wb_we_q     <= 1'b0;
      take_q      <= 1'b0;
      offset_q    <= 16'h0;
    end else begin
      pc_q        <= pc_d;
      instr_reg_q <= instr_d;
      cpsr_q      <= cpsr_d;
      wb_we_q     <= wb_we_d;
      take_q      <= take_d;
      offset_q    <= offset_d;
    end
  end

  assign pc      = pc_q;
  assign instr_q = instr_reg_q;
  assign cpsr    = cpsr_q;

endmodule

// File: doc/ex_ctrl.md
EX_CTRL -- requirements
Module: ex_ctrl

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd1: PC increment for non-branch instructions (word-addressed memory).
REQ-003 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse; leaves IDLE.
REQ-007 fetch_req  out  1  instruction fetch request to instruction memory.
REQ-008 imem_ready  in  1  instruction memory has imem_rdata valid this cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 instr_q  out  32  latched instruction presented to ID.
REQ-011 pc  out  32  current program counter, also the fetch address.
REQ-012 dec_special  in  1  ID Special_encoding: 1 = ALU class.
REQ-013 dec_first_ld  in  2  ID First_LD.
REQ-014 dec_alu_oc  in  3  ID ALU_OC.
REQ-015 dec_b_cond  in  4  ID B_cond.
REQ-016 dec_set_flags  in  1  ID Second_LD[3]: ALU op updates CPSR.
REQ-017 dec_offset  in  16  signed branch offset.
REQ-018 ex_flags  in  4  flags computed by EX this cycle, {N,C,Z,V}.
REQ-019 w_enable  out  1  register-file write strobe.
REQ-020 cpsr  out  4  registered flags {N,C,Z,V}, bit3 = N, bit0 = V; feeds EX.
REQ-021 branch_taken  out  1  one-cycle pulse when the PC is loaded with a branch target.
REQ-022 halted  out  1  high in HALT.

Function
REQ-023 FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-024 IDLE: start=1 moves to FETCH next cycle; all other inputs are ignored.
REQ-025 FETCH: fetch_req=1 and pc is stable until imem_ready=1.
REQ-026 FETCH handshake: on the first cycle with imem_ready=1, imem_rdata is latched into instr_q and the FSM moves to DECODE.
REQ-027 FETCH stall: no cycle limit; fetch_req drops the cycle after the accept.
REQ-028 DECODE lasts exactly one cycle, then EXECUTE.
REQ-029 EXECUTE lasts one cycle; dec_* and ex_flags are sampled on that cycle's rising edge.
REQ-030 EXECUTE, system op (dec_special=0, dec_first_ld!=0, dec_alu_oc=3'b111): next state is HALT; pc, cpsr and w_enable are unchanged.
REQ-031 EXECUTE, all other ops: next state is WRITEBACK.
REQ-032 CPSR update: cpsr <= ex_flags at the end of EXECUTE only when dec_special=1 and dec_set_flags=1; otherwise cpsr holds.
REQ-033 WRITEBACK lasts one cycle, then FETCH.
REQ-034 WRITEBACK w_enable: 1 for that single cycle when dec_special=1, or when dec_first_ld=2'b00 (MOV/MOVT/LSL/LSR/CLR/SET class); 0 for branches.
REQ-035 Branch class = dec_special=0, dec_first_ld!=0, dec_alu_oc=3'b000 (unconditional) or 3'b001 (conditional on dec_b_cond).
REQ-036 Condition codes: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !(C&!Z); 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 !(!Z&(N==V)); 1110 always; 1111 never.
REQ-037 Conditions are evaluated on the cpsr value registered before this instruction.
REQ-038 PC update at end of WRITEBACK: taken branch gives pc <= pc + sign_extend32(dec_offset) and branch_taken=1 in WRITEBACK; otherwise pc <= pc + PC_STEP.
REQ-039 PC arithmetic is modulo 2^32; wrap-around is silent.
REQ-040 HALT is terminal until reset; start is ignored; halted=1; fetch_req=0 and w_enable=0.
REQ-041 start asserted in any state other than IDLE is ignored.

Reset
REQ-042 While rst_n=0, state=IDLE, pc=PC_RESET, instr_q=0, cpsr=4'b0000, and fetch_req, w_enable, branch_taken, halted are all 0, regardless of clk.
REQ-043 Reset asserted mid-fetch or mid-execute aborts the instruction; no w_enable pulse and no pc change occur after rst_n falls.
REQ-044 After rst_n rises, the first state change needs a start pulse.

Structure
REQ-045 Shared package ex_ctrl_pkg holds the state enum, the 16 condition-code constants, the flag bit indices (N=3, C=2, Z=1, V=0) and the op-class constants (branch 3'b000/3'b001, system 3'b111).
REQ-046 Condition evaluation is one combinational sub-module, cond_eval (cond[3:0], flags[3:0] -> take).
REQ-047 All other logic (FSM, pc, cpsr, instr_q) is in ex_ctrl.

Verification
REQ-048 Reset then start, imem_ready tied 1, ALU ADD with dec_set_flags=1, ex_flags=4'b0010 -> FETCH/DECODE/EXECUTE/WRITEBACK in 4 cycles; w_enable one cycle; cpsr=4'b0010; pc=1.
REQ-049 imem_ready held 0 for 5 cycles -> fetch_req high for 6 cycles; pc and instr_q stable; accept on cycle 6.
REQ-050 cpsr=4'b0010, BEQ (b_cond=0000) offset=16'hFFFC at pc=8 -> branch_taken pulse, pc=4, w_enable=0; same with cpsr=0 -> pc=9.
REQ-051 pc=32'hFFFF_FFFF, non-branch op -> pc wraps to 0; branch offset 16'h0002 from 32'hFFFF_FFFF -> pc=1.
REQ-052 System op 3'b111 -> halted=1 with no w_enable; later start pulses ignored; rst_n low restores IDLE, pc=PC_RESET, cpsr=0.
REQ-053 rst_n dropped mid-cycle during EXECUTE -> outputs reset immediately; no w_enable or pc change follows.
